// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the IF-stage fetch port, the MEM-stage data port
// and the shared single-port external memory. The arbiter uses the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_ready;
  logic                  i_stall;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_ready;
  logic                  d_stall;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_rdata,
    output i_rdata, i_ready, i_stall,
    output d_rdata, d_ready, d_stall,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output mem_rdata,
    input  i_rdata, i_ready, i_stall,
    input  d_rdata, d_ready, d_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the I and D ports (issue -> wait -> respond).
// Optional ARB_RR_EN: idle-state ties go to the port that was not granted last (default: D wins).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic       PORT_I  = 1'b0;
  localparam logic       PORT_D  = 1'b1;
  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                acc_we_q, acc_we_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                grant_s;
  logic                d_wins_s;
  logic                other_req_s;

  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                i_ready_s, d_ready_s;

  // From RESP only the port that was not just served may be granted.
  assign other_req_s = (gnt_q == PORT_D) ? bus.i_req : bus.d_req;

`ifdef ARB_RR_EN
  logic last_gnt_q;

  // Remembers the most recent grant so that idle ties alternate.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q <= PORT_I;
    end else if (grant_s) begin
      last_gnt_q <= gnt_d;
    end else begin
      last_gnt_q <= last_gnt_q;
    end
  end

  assign d_wins_s = (last_gnt_q == PORT_I);
`else
  assign d_wins_s = 1'b1;
`endif

  // State and registered-output flops; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= PORT_I;
      acc_we_q    <= 1'b0;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      acc_we_q    <= acc_we_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  // Next-state and grant selection.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    grant_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          grant_s = 1'b1;
          gnt_d   = (bus.d_req && (d_wins_s || !bus.i_req)) ? PORT_D : PORT_I;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (other_req_s) begin
          grant_s = 1'b1;
          gnt_d   = ~gnt_q;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered memory command, latency counter and port responses.
  always_comb begin
    cnt_d       = cnt_q;
    acc_we_d    = acc_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;

    if (grant_s) begin
      mem_en_d = 1'b1;
      if (gnt_d == PORT_D) begin
        mem_we_d    = bus.d_we;
        acc_we_d    = bus.d_we;
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_we ? bus.d_wdata : '0;
        mem_wstrb_d = bus.d_we ? bus.d_wstrb : '0;
      end else begin
        mem_we_d    = 1'b0;
        acc_we_d    = 1'b0;
        mem_addr_d  = bus.i_addr;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
      end
    end else begin
      mem_en_d = 1'b0;
    end

    case (state_q)
      ST_ISSUE: begin
        cnt_d = LAT_CNT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // mem_rdata is only valid in the final wait cycle.
        if (cnt_q == 4'd1) begin
          if (gnt_q == PORT_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = acc_we_q ? d_rdata_q : bus.mem_rdata;
          end else begin
            i_ready_d = 1'b1;
            i_rdata_d = bus.mem_rdata;
          end
        end else begin
          i_ready_d = 1'b0;
          d_ready_d = 1'b0;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // A requester that illegally dropped its request sees no completion pulse.
  assign i_ready_s     = i_ready_q & bus.i_req;
  assign d_ready_s     = d_ready_q & bus.d_req;

  assign bus.i_ready   = i_ready_s;
  assign bus.d_ready   = d_ready_s;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.i_stall   = bus.i_req & ~i_ready_s;
  assign bus.d_stall   = bus.d_req & ~d_ready_s;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
